// File: rtl/cpu_subsys_mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port memory slave; all s_* outputs registered.
// Optional BUSY watchdog (aborts with ERR_RDATA) is enabled by defining CPU_SUBSYS_ARB_TIMEOUT_EN.
module cpu_subsys_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q;
  logic        grant_q;
  logic        last_q;
  logic        s_valid_q;
  logic [31:0] s_addr_q;
  logic [31:0] s_wdata_q;
  logic [3:0]  s_wstrb_q;
  logic        m0_ready_q;
  logic        m1_ready_q;
  logic [31:0] m0_rdata_q;
  logic [31:0] m1_rdata_q;

  logic        grant_d;
  logic        done_d;
  logic        abort_d;
  logic [31:0] rsp_d;

  // last_q names the master served most recently; a tie goes to the other one.
  always_comb begin
    grant_d = m1_valid & (~m0_valid | ~last_q);
  end

`ifdef CPU_SUBSYS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt_q;
  logic          timeout_q;

  always_comb begin
    abort_d = (state_q == BUSY) && !s_ready && (cnt_q == TMAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= abort_d;
      if (state_q != BUSY) cnt_q <= '0;
      else if (!s_ready && !abort_d) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign timeout_err = timeout_q;
`else
  always_comb begin
    abort_d = 1'b0;
  end

  assign timeout_err = 1'b0;
`endif

  always_comb begin
    done_d = (state_q == BUSY) && (s_ready || abort_d);
    rsp_d  = s_ready ? s_rdata : ERR_RDATA;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      last_q     <= 1'b1;
      s_valid_q  <= 1'b0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      s_wstrb_q  <= '0;
      m0_ready_q <= 1'b0;
      m1_ready_q <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      m0_ready_q <= 1'b0;
      m1_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (m0_valid || m1_valid) begin
            grant_q   <= grant_d;
            s_valid_q <= 1'b1;
            s_addr_q  <= grant_d ? m1_addr  : m0_addr;
            s_wdata_q <= grant_d ? m1_wdata : m0_wdata;
            s_wstrb_q <= grant_d ? m1_wstrb : m0_wstrb;
            state_q   <= BUSY;
          end
        end
        BUSY: begin
          if (done_d) begin
            if (grant_q) begin
              m1_ready_q <= 1'b1;
              m1_rdata_q <= rsp_d;
            end else begin
              m0_ready_q <= 1'b1;
              m0_rdata_q <= rsp_d;
            end
            s_valid_q <= 1'b0;
            last_q    <= grant_q;
            state_q   <= DONE;
          end
        end
        DONE: begin
          // The slave's ready is level-held one cycle past s_valid; wait for it to clear.
          if (!s_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_valid  = s_valid_q;
  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign s_wstrb  = s_wstrb_q;
  assign m0_ready = m0_ready_q;
  assign m1_ready = m1_ready_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;

endmodule
